// File: rtl/player_controller.sv
// Player pose controller: on each serviced frame tick, rotate and move the camera
// pose from a button snapshot, checking the map for walls before committing.
module player_controller #(
    parameter logic [15:0] INIT_POS_X   = 16'h0C00,
    parameter logic [15:0] INIT_POS_Y   = 16'h0C00,
    parameter logic [15:0] INIT_DIR_X   = 16'h0100,
    parameter logic [15:0] INIT_DIR_Y   = 16'h0000,
    parameter logic [15:0] INIT_PLANE_X = 16'h0000,
    parameter logic [15:0] INIT_PLANE_Y = 16'h00A9,
    parameter logic [15:0] ROT_COS      = 16'h00FE,
    parameter logic [15:0] ROT_SIN      = 16'h0020,
    parameter logic [15:0] MOVE_SPEED   = 16'h0020,
    parameter int          MAP_SIZE     = 24
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        frame_tick_in,
    input  logic        rays_busy_in,
    input  logic        fwd_in,
    input  logic        bwd_in,
    input  logic        left_in,
    input  logic        right_in,
    output logic [9:0]  map_addr_out,
    output logic        map_req_out,
    input  logic        map_rvalid_in,
    input  logic [3:0]  map_wall_in,
    output logic [15:0] posX_out,
    output logic [15:0] posY_out,
    output logic [15:0] dirX_out,
    output logic [15:0] dirY_out,
    output logic [15:0] planeX_out,
    output logic [15:0] planeY_out,
    output logic        pose_update_out,
    output logic        busy_out
);
    typedef enum logic [2:0] {IDLE, ROT, MOVE, MAP_WAIT, COMMIT} state_t;

    localparam logic [7:0] MAP_LIM = 8'(MAP_SIZE);
    localparam logic [9:0] MAP_W   = 10'(MAP_SIZE);

    state_t state, state_nx;

    logic        pending, service;
    logic        btn_fwd, btn_bwd, btn_left, btn_right;
    logic [15:0] snap_dir_x, snap_dir_y, snap_plane_x, snap_plane_y;
    logic [15:0] rot_dir_x, rot_dir_y, rot_plane_x, rot_plane_y;
    logic [15:0] cand_x, cand_y, next_x, next_y, delta_x, delta_y;
    logic        moving, in_bounds, accept;
    logic [9:0]  cand_addr;

    function automatic logic signed [31:0] mul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] ea, eb;
        ea = {{16{a[15]}}, a};
        eb = {{16{b[15]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [15:0] fx(input logic signed [31:0] v);
        logic signed [31:0] s;
        s = v >>> 8;
        return s[15:0];
    endfunction

    // Returns {x', y'}; en=0 leaves the vector untouched (no or both turn buttons).
    function automatic logic [31:0] rotate(input logic [15:0] x, input logic [15:0] y,
                                           input logic turn_left, input logic en);
        if (!en)
            return {x, y};
        if (turn_left)
            return {fx(mul(x, ROT_COS) - mul(y, ROT_SIN)), fx(mul(x, ROT_SIN) + mul(y, ROT_COS))};
        return {fx(mul(x, ROT_COS) + mul(y, ROT_SIN)), fx(mul(y, ROT_COS) - mul(x, ROT_SIN))};
    endfunction

    assign service     = (state == IDLE) && (frame_tick_in || pending) && !rays_busy_in;
    assign busy_out    = (state != IDLE);
    assign map_req_out = (state == MAP_WAIT);

    // Move uses the pre-rotation dir snapshot, never the freshly rotated one.
    always_comb begin
        delta_x   = fx(mul(snap_dir_x, MOVE_SPEED));
        delta_y   = fx(mul(snap_dir_y, MOVE_SPEED));
        next_x    = btn_fwd ? posX_out + delta_x : posX_out - delta_x;
        next_y    = btn_fwd ? posY_out + delta_y : posY_out - delta_y;
        moving    = btn_fwd ^ btn_bwd;
        in_bounds = !next_x[15] && !next_y[15] && (next_x[15:8] < MAP_LIM) && (next_y[15:8] < MAP_LIM);
        cand_addr = 10'(next_y[15:8]) * MAP_W + 10'(next_x[15:8]);
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (service) state_nx = ROT;
            ROT:      state_nx = MOVE;
            MOVE:     state_nx = (moving && in_bounds) ? MAP_WAIT : COMMIT;
            MAP_WAIT: if (map_rvalid_in) state_nx = COMMIT;
            COMMIT:   state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            pending         <= 1'b0;
            pose_update_out <= 1'b0;
            map_addr_out    <= '0;
            accept          <= 1'b0;
            {btn_fwd, btn_bwd, btn_left, btn_right} <= '0;
            {snap_dir_x, snap_dir_y, snap_plane_x, snap_plane_y} <= '0;
            {rot_dir_x, rot_dir_y, rot_plane_x, rot_plane_y}     <= '0;
            cand_x          <= '0;
            cand_y          <= '0;
            posX_out        <= INIT_POS_X;
            posY_out        <= INIT_POS_Y;
            dirX_out        <= INIT_DIR_X;
            dirY_out        <= INIT_DIR_Y;
            planeX_out      <= INIT_PLANE_X;
            planeY_out      <= INIT_PLANE_Y;
        end else begin
            pose_update_out <= (state == COMMIT);
            if (service)
                pending <= 1'b0;
            else if (frame_tick_in)
                pending <= 1'b1;

            case (state)
                IDLE: if (service) begin
                    {btn_fwd, btn_bwd, btn_left, btn_right} <= {fwd_in, bwd_in, left_in, right_in};
                    snap_dir_x   <= dirX_out;
                    snap_dir_y   <= dirY_out;
                    snap_plane_x <= planeX_out;
                    snap_plane_y <= planeY_out;
                    accept       <= 1'b0;
                end
                ROT: begin
                    {rot_dir_x, rot_dir_y}     <= rotate(snap_dir_x, snap_dir_y, btn_left, btn_left ^ btn_right);
                    {rot_plane_x, rot_plane_y} <= rotate(snap_plane_x, snap_plane_y, btn_left, btn_left ^ btn_right);
                end
                MOVE: begin
                    cand_x <= next_x;
                    cand_y <= next_y;
                    if (moving && in_bounds)
                        map_addr_out <= cand_addr;
                end
                MAP_WAIT: if (map_rvalid_in && map_wall_in == 4'd0) accept <= 1'b1;
                COMMIT: begin
                    dirX_out   <= rot_dir_x;
                    dirY_out   <= rot_dir_y;
                    planeX_out <= rot_plane_x;
                    planeY_out <= rot_plane_y;
                    if (accept) begin
                        posX_out <= cand_x;
                        posY_out <= cand_y;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_player_controller.sv
// Randomized self-checking bench for player_controller against an integer pose model
// with a scripted map responder.
module tb_player_controller;
    logic        clk = 1'b0;
    logic        rst_in, frame_tick_in, rays_busy_in;
    logic        fwd_in, bwd_in, left_in, right_in;
    logic [9:0]  map_addr_out;
    logic        map_req_out, map_rvalid_in;
    logic [3:0]  map_wall_in;
    logic [15:0] posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out;
    logic        pose_update_out, busy_out;

    player_controller dut (
        .pixel_clk_in(clk), .rst_in(rst_in), .frame_tick_in(frame_tick_in),
        .rays_busy_in(rays_busy_in), .fwd_in(fwd_in), .bwd_in(bwd_in),
        .left_in(left_in), .right_in(right_in), .map_addr_out(map_addr_out),
        .map_req_out(map_req_out), .map_rvalid_in(map_rvalid_in), .map_wall_in(map_wall_in),
        .posX_out(posX_out), .posY_out(posY_out), .dirX_out(dirX_out), .dirY_out(dirY_out),
        .planeX_out(planeX_out), .planeY_out(planeY_out),
        .pose_update_out(pose_update_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    localparam int C = 254, S = 32, MS = 32, MAPN = 24;

    int nvec = 0, nerr = 0;
    int walls[576];
    int mx, my, mdx, mdy, mpx, mpy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int t16(input int v);
        int r;
        r = v & 'hFFFF;
        if (r >= 32768) r -= 65536;
        return r;
    endfunction

    task automatic model_reset();
        mx = 3072; my = 3072; mdx = 256; mdy = 0; mpx = 0; mpy = 169;
    endtask

    task automatic check_pose();
        chk("posX", 32'(posX_out), mx & 'hFFFF);
        chk("posY", 32'(posY_out), my & 'hFFFF);
        chk("dirX", 32'(dirX_out), mdx & 'hFFFF);
        chk("dirY", 32'(dirY_out), mdy & 'hFFFF);
        chk("planeX", 32'(planeX_out), mpx & 'hFFFF);
        chk("planeY", 32'(planeY_out), mpy & 'hFFFF);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_update", 32'(pose_update_out), 0);
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_req", 32'(map_req_out), 0);
        chk("rst_addr", 32'(map_addr_out), 0);
        rst_in = 1'b0;
        model_reset();
        check_pose();
    endtask

    // Called at the negedge right after the servicing edge; follows the frame to its update.
    task automatic serve(input bit f, input bit b, input bit l, input bit r, input int lat);
        int ndx, ndy, npx, npy, nx, ny, d, cx, cy, addr, k, exp_n;
        bit look, done;
        ndx = mdx; ndy = mdy; npx = mpx; npy = mpy;
        if (l && !r) begin
            ndx = t16((mdx*C - mdy*S) >>> 8); ndy = t16((mdx*S + mdy*C) >>> 8);
            npx = t16((mpx*C - mpy*S) >>> 8); npy = t16((mpx*S + mpy*C) >>> 8);
        end else if (r && !l) begin
            ndx = t16((mdx*C + mdy*S) >>> 8); ndy = t16((mdy*C - mdx*S) >>> 8);
            npx = t16((mpx*C + mpy*S) >>> 8); npy = t16((mpy*C - mpx*S) >>> 8);
        end
        nx = mx; ny = my; look = 0; addr = 0;
        if (f != b) begin
            d  = f ? 1 : -1;
            cx = t16(mx + d * t16((mdx*MS) >>> 8));
            cy = t16(my + d * t16((mdy*MS) >>> 8));
            if (cx >= 0 && cy >= 0 && (cx >>> 8) < MAPN && (cy >>> 8) < MAPN) begin
                look = 1;
                addr = (cy >>> 8) * MAPN + (cx >>> 8);
                if (walls[addr] == 0) begin nx = cx; ny = cy; end
            end
        end
        exp_n = look ? 5 + lat : 4;
        k = 0; done = 0;
        for (int n = 1; n <= 64 && !done; n++) begin
            if (map_req_out) begin
                if (k == 0) chk("map_addr", 32'(map_addr_out), addr);
                map_rvalid_in = (k == lat);
                map_wall_in = (map_addr_out < 576) ? 4'(walls[map_addr_out]) : 4'd0;
                k++;
            end else begin
                map_rvalid_in = 1'b0;
            end
            if (n == 3) chk("pose_hold", 32'(posX_out), mx & 'hFFFF);
            if (pose_update_out) begin
                done = 1;
                chk("latency", n, exp_n);
                chk("lookup", 32'(k > 0), 32'(look));
                mx = nx; my = ny; mdx = ndx; mdy = ndy; mpx = npx; mpy = npy;
                check_pose();
            end
            @(negedge clk);
        end
        map_rvalid_in = 1'b0;
        if (!done) chk("timeout", 0, 1);
    endtask

    task automatic run_tick(input bit f, input bit b, input bit l, input bit r, input int lat);
        fwd_in = f; bwd_in = b; left_in = l; right_in = r;
        frame_tick_in = 1'b1;
        @(negedge clk);
        frame_tick_in = 1'b0;
        chk("busy_rise", 32'(busy_out), 1);
        // buttons change after the snapshot; the frame must not see this
        fwd_in = 1'($urandom_range(0, 1)); bwd_in = 1'($urandom_range(0, 1));
        left_in = 1'($urandom_range(0, 1)); right_in = 1'($urandom_range(0, 1));
        serve(f, b, l, r, lat);
    endtask

    initial begin
        bit extra;
        int w;
        rst_in = 1'b1; frame_tick_in = 0; rays_busy_in = 0;
        fwd_in = 0; bwd_in = 0; left_in = 0; right_in = 0;
        map_rvalid_in = 0; map_wall_in = 0;
        for (int i = 0; i < 576; i++)
            walls[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0;
        for (int i = 288; i < 312; i++) walls[i] = 0;
        @(negedge clk);

        do_reset();
        run_tick(0, 0, 0, 0, 0);
        chk("idle_dirX", 32'(dirX_out), 32'h0100);
        chk("idle_planeY", 32'(planeY_out), 32'h00A9);
        run_tick(0, 0, 1, 0, 0);
        chk("left_dirX", 32'(dirX_out), 32'h00FE);
        chk("left_dirY", 32'(dirY_out), 32'h0020);
        chk("left_planeX", 32'(planeX_out), 32'hFFEA);
        chk("left_planeY", 32'(planeY_out), 32'h00A7);
        do_reset();
        run_tick(0, 0, 0, 1, 0);
        chk("right_dirY", 32'(dirY_out), 32'hFFE0);
        chk("right_planeX", 32'(planeX_out), 32'h0015);
        chk("right_planeY", 32'(planeY_out), 32'h00A7);

        do_reset();
        run_tick(1, 0, 0, 0, 5);
        chk("fwd_open", 32'(posX_out), 32'h0C20);
        do_reset();
        walls[300] = 3;
        run_tick(1, 0, 0, 0, 5);
        chk("fwd_wall", 32'(posX_out), 32'h0C00);
        walls[300] = 0;

        // two ticks while the ray pipeline is busy collapse into one service
        do_reset();
        rays_busy_in = 1'b1; frame_tick_in = 1'b1;
        @(negedge clk);
        frame_tick_in = 1'b0;
        chk("busy_hold1", 32'(busy_out), 0);
        repeat (2) @(negedge clk);
        frame_tick_in = 1'b1;
        @(negedge clk);
        frame_tick_in = 1'b0;
        @(negedge clk);
        chk("busy_hold2", 32'(busy_out), 0);
        fwd_in = 0; bwd_in = 0; left_in = 1; right_in = 0;
        rays_busy_in = 1'b0;
        @(negedge clk);
        chk("busy_after_drop", 32'(busy_out), 1);
        serve(0, 0, 1, 0, 0);
        extra = 0;
        repeat (8) begin
            if (pose_update_out || busy_out) extra = 1;
            @(negedge clk);
        end
        chk("single_service", 32'(extra), 0);

        // reset while waiting on the map
        do_reset();
        fwd_in = 1; bwd_in = 0; left_in = 0; right_in = 0;
        frame_tick_in = 1'b1;
        @(negedge clk);
        frame_tick_in = 1'b0;
        w = 0;
        while (!map_req_out && w < 10) begin @(negedge clk); w++; end
        chk("mapwait_reached", 32'(map_req_out), 1);
        rst_in = 1'b1;
        @(negedge clk);
        chk("rst_mw_req", 32'(map_req_out), 0);
        chk("rst_mw_busy", 32'(busy_out), 0);
        check_pose();
        rst_in = 1'b0; fwd_in = 0;
        map_rvalid_in = 1'b1; map_wall_in = 4'd0;
        @(negedge clk);
        map_rvalid_in = 1'b0;
        extra = 0;
        repeat (6) begin
            if (pose_update_out || busy_out) extra = 1;
            @(negedge clk);
        end
        chk("stale_rvalid", 32'(extra), 0);
        check_pose();

        // walk to the far edge of row 12, then back past zero
        do_reset();
        for (int i = 0; i < 96; i++) run_tick(1, 0, 0, 0, i % 3);
        chk("edge_hi", 32'(posX_out), 32'h17E0);
        for (int i = 0; i < 192; i++) run_tick(0, 1, 0, 0, 0);
        chk("edge_lo", 32'(posX_out), 32'h0000);

        do_reset();
        repeat (150)
            run_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 4)));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
